wts_channel_scheduler: RTL
==========================

WTS_CHANNEL_SCHEDULER -- requirements
Module: wts_channel_scheduler

Interface
REQ-001 Parameter SLOT_CYCLES, default 4, cycles per channel slot (legal 2..16).
REQ-002 Parameter FRAME_GAP, default 2, idle cycles after the last slot of a frame (legal 1..15).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  run request; sampled only in IDLE and at frame end.
REQ-006 ch_enable  input  5  per-channel enable; bit 0 is channel A, bit 4 is channel E.
REQ-007 active  output  3  channel index 0..4 driven to the 5-way register selector; 7 when no slot is running.
REQ-008 phase  output  4  cycle index within the current slot, 0..SLOT_CYCLES-1; 0 outside slots.
REQ-009 slot_valid  output  1  current slot belongs to an enabled channel.
REQ-010 acc_clear  output  1  one-cycle pulse on the first cycle of each frame.
REQ-011 frame_done  output  1  one-cycle pulse on the first GAP cycle.
REQ-012 cpu_req  input  1  level request for wave-RAM/register access.
REQ-013 cpu_ack  output  1  one-cycle grant pulse; the access occurs in that cycle.

Function
REQ-014 The FSM SHALL have states IDLE, SLOT and GAP.
REQ-015 IDLE: active=7, phase=0, slot_valid=0; when enable=1, the next cycle SHALL be SLOT at the first scheduled channel with phase=0 and acc_clear=1.
REQ-016 SLOT: phase SHALL increment each cycle; at phase=SLOT_CYCLES-1, active SHALL advance to the next scheduled channel with phase=0, or go to GAP after the last scheduled channel.
REQ-017 slot_valid SHALL equal ch_enable[active], sampled at the slot's phase 0 and held for the whole slot.
REQ-018 GAP SHALL last exactly FRAME_GAP cycles with active=7; on its last cycle, enable=1 SHALL start a new frame (acc_clear=1 next cycle), and enable=0 SHALL go to IDLE.
REQ-019 Deasserting enable mid-frame SHALL NOT abort the frame; the frame completes, including GAP.
REQ-020 ch_enable changes SHALL take effect at the next slot boundary only.
REQ-021 With default parameters and all channels scheduled, frame length SHALL be 5*4+2 = 22 cycles, with acc_clear pulses spaced exactly 22 cycles apart.
REQ-022 cpu_ack SHALL be asserted only in IDLE or GAP, when cpu_req=1 and cpu_ack was 0 in the previous cycle; it SHALL never be asserted in SLOT.
REQ-023 If cpu_req is held, cpu_ack SHALL pulse every second grant-window cycle.
REQ-024 A request arriving during SLOT SHALL wait for the first GAP cycle, where cpu_ack SHALL assert in the same cycle as frame_done.

Reset
REQ-025 While reset=1, the FSM SHALL be in IDLE with active=7, phase=0, slot_valid=0, acc_clear=0, frame_done=0 and cpu_ack=0, and no pulse SHALL be emitted.
REQ-026 Reset asserted mid-frame SHALL abandon the frame immediately, with no frame_done pulse.
REQ-027 After reset deasserts, the first frame SHALL start on the cycle after enable=1 is first sampled.

Configuration
REQ-028 Macro WTS_SCHED_SKIP_DISABLED_EN.
REQ-029 When defined, channels whose ch_enable bit is 0 at the boundary SHALL receive no slot, and slot_valid SHALL always be 1 in SLOT.
REQ-030 When defined and ch_enable=0, a frame SHALL go directly to GAP: acc_clear and frame_done SHALL pulse in the same cycle, and the frame length SHALL be FRAME_GAP.
REQ-031 When undefined, all five slots SHALL always run in order 0..4, and a disabled channel SHALL show slot_valid=0.

Verification
REQ-032 Reset, then enable=1 and ch_enable=5'b11111 -> active sequence 0,0,0,0,1,...,4,7,7; acc_clear at cycle 1 and cycle 23; frame_done at cycle 21.
REQ-033 Without the macro, ch_enable=5'b10101 -> 22-cycle frame; slot_valid=1 for channels 0, 2 and 4 and 0 for channels 1 and 3.
REQ-034 With the macro, ch_enable=5'b10010 -> active 1,1,1,1,4,4,4,4,7,7; frame length 10.
REQ-035 cpu_req raised in phase 1 of channel 2 -> no cpu_ack until the first GAP cycle, where cpu_ack and frame_done coincide; cpu_req held -> no second ack in a 2-cycle GAP.
REQ-036 enable dropped in channel 3 -> frame completes, then IDLE; reset at channel 2, phase 2 -> active=7 immediately and no frame_done.

Source files
------------

// File: rtl/wts_channel_scheduler.sv
// Wave-table channel scheduler: time-slices five channels per frame and grants CPU access outside slots.
// Optional build macro WTS_SCHED_SKIP_DISABLED_EN: disabled channels receive no slot at all.
module wts_channel_scheduler #(
  parameter int SLOT_CYCLES = 4,
  parameter int FRAME_GAP   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] ch_enable,
  input  logic       cpu_req,
  output logic [2:0] active,
  output logic [3:0] phase,
  output logic       slot_valid,
  output logic       acc_clear,
  output logic       frame_done,
  output logic       cpu_ack
);

  localparam logic [3:0] PH_LAST  = 4'(SLOT_CYCLES - 1);
  localparam logic [3:0] GAP_LAST = 4'(FRAME_GAP - 1);
  localparam logic [2:0] NO_CH    = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOT = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] gap_cnt;
  logic [4:0] sched_mask;
  logic [3:0] first_ch;
  logic [3:0] succ_ch;
  logic       win_nxt;

  // Lowest scheduled channel at or above 'from'; result is {found, index}.
  function automatic logic [3:0] find_next(input logic [2:0] from, input logic [4:0] mask);
    logic [3:0] r;
    r = {1'b0, NO_CH};
    for (int i = 4; i >= 0; i--) begin
      if (mask[i] && (3'(i) >= from)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

`ifdef WTS_SCHED_SKIP_DISABLED_EN
  assign sched_mask = ch_enable;
`else
  assign sched_mask = 5'b11111;
`endif

  // win_nxt: the coming cycle is IDLE or GAP, so a CPU grant may land there.
  always_comb begin
    first_ch = find_next(3'd0, sched_mask);
    succ_ch  = find_next(active + 3'd1, sched_mask);
    win_nxt  = 1'b0;
    case (state)
      IDLE:    win_nxt = !(enable && first_ch[3]);
      SLOT:    win_nxt = (phase == PH_LAST) && !succ_ch[3];
      GAP:     win_nxt = !((gap_cnt == GAP_LAST) && enable && first_ch[3]);
      default: win_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      gap_cnt    <= 4'd0;
      active     <= NO_CH;
      phase      <= 4'd0;
      slot_valid <= 1'b0;
      acc_clear  <= 1'b0;
      frame_done <= 1'b0;
      cpu_ack    <= 1'b0;
    end else begin
      acc_clear  <= 1'b0;
      frame_done <= 1'b0;
      cpu_ack    <= cpu_req && !cpu_ack && win_nxt;
      case (state)
        IDLE: begin
          if (enable) begin
            acc_clear <= 1'b1;
            if (first_ch[3]) begin
              state      <= SLOT;
              active     <= first_ch[2:0];
              phase      <= 4'd0;
              slot_valid <= ch_enable[first_ch[2:0]];
            end else begin
              // Nothing scheduled: the frame collapses to its gap.
              state      <= GAP;
              gap_cnt    <= 4'd0;
              frame_done <= 1'b1;
            end
          end
        end
        SLOT: begin
          if (phase == PH_LAST) begin
            if (succ_ch[3]) begin
              active     <= succ_ch[2:0];
              phase      <= 4'd0;
              slot_valid <= ch_enable[succ_ch[2:0]];
            end else begin
              state      <= GAP;
              gap_cnt    <= 4'd0;
              active     <= NO_CH;
              phase      <= 4'd0;
              slot_valid <= 1'b0;
              frame_done <= 1'b1;
            end
          end else begin
            phase <= phase + 4'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (enable) begin
              acc_clear <= 1'b1;
              if (first_ch[3]) begin
                state      <= SLOT;
                active     <= first_ch[2:0];
                phase      <= 4'd0;
                slot_valid <= ch_enable[first_ch[2:0]];
              end else begin
                gap_cnt    <= 4'd0;
                frame_done <= 1'b1;
              end
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state      <= IDLE;
          active     <= NO_CH;
          phase      <= 4'd0;
          slot_valid <= 1'b0;
        end
      endcase
    end
  end

  a_no_ack_in_slot: assert property (@(posedge clk) disable iff (reset)
    !(cpu_ack && state == SLOT));
  a_no_back_to_back_ack: assert property (@(posedge clk) disable iff (reset)
    cpu_ack |=> !cpu_ack);

endmodule
